// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Multiplexed seven-segment driver: sequential binary-to-BCD load,
//           leading-zero blanking, per-digit decimal points, overflow dashes.
// Rev     : 1.0
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BIN_W-1:0]  value,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        led,
    output logic [DIGITS-1:0] anode
);

    localparam int c_bcd_w  = 4 * DIGITS;
    localparam int c_step_w = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int c_idx_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_ref_w  = $clog2(REFRESH_DIV);

    localparam logic [63:0]         c_max_val   = 64'(10 ** DIGITS - 1);
    localparam logic [c_step_w-1:0] c_last_step = c_step_w'(BIN_W - 1);
    localparam logic [c_idx_w-1:0]  c_last_idx  = c_idx_w'(DIGITS - 1);
    localparam logic [c_ref_w-1:0]  c_last_ref  = c_ref_w'(REFRESH_DIV - 1);
    localparam logic [DIGITS-1:0]   c_anode_one = DIGITS'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [BIN_W-1:0]     r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_bcd_w-1:0]   w_bcd_adj;
    logic [c_bcd_w-1:0]   w_bcd_next;
    logic [c_step_w-1:0]  r_step;
    logic                 r_ovf_pend;
    logic [c_bcd_w-1:0]   r_digits;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_value_ovf;

    logic [c_ref_w-1:0]   r_refresh;
    logic [c_idx_w-1:0]   r_idx;
    logic [DIGITS-1:0]    w_blank;
    logic [7:0]           w_seg [DIGITS];

    assign busy        = (r_state == S_CONV);
    assign w_accept    = load && !busy;
    assign w_last      = busy && (r_step == c_last_step);
    assign w_value_ovf = (64'(value) > c_max_val);

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CONV;
            S_CONV:  if (r_step == c_last_step) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift-add-3: adjust every nibble, then shift in the next binary MSB.
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                     r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end

    // Bits shifted out above the top nibble are intentionally dropped.
    assign w_bcd_next = c_bcd_w'({w_bcd_adj, r_bin[BIN_W-1]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_step     <= '0;
            r_ovf_pend <= 1'b0;
            r_digits   <= '0;
            overflow   <= 1'b0;
        end else if (w_accept) begin
            r_bin      <= value;
            r_bcd      <= '0;
            r_step     <= '0;
            r_ovf_pend <= w_value_ovf;
        end else if (busy) begin
            r_bin  <= r_bin << 1;
            r_bcd  <= w_bcd_next;
            r_step <= r_step + 1'b1;
            if (w_last) begin
                r_digits <= w_bcd_next;
                overflow <= r_ovf_pend;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // A digit is blanked when it and every digit above it are zero; digit 0 never.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        w_blank  = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (r_digits[4*i +: 4] == 4'd0);
            w_blank[i] = blank_lz && zero_run;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_seg
        assign w_seg[i] = overflow ? 8'hBF :
                          {~dp_mask[i],
                           (w_blank[i] ? 7'h7F : seg_decode(r_digits[4*i +: 4]))};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
            led       <= 8'hFF;
            anode     <= '1;
        end else begin
            if (r_refresh == c_last_ref) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            // Both outputs come from the same index, so they switch together.
            led   <= w_seg[r_idx];
            anode <= ~(c_anode_one << r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Directed self-checking bench for seg7_scan_driver with a queue of
//           expected values popped as the display produces output.
// Rev     : 1.0
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIGITS      = 4;
    localparam int BIN_W       = 14;
    localparam int REFRESH_DIV = 4;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              load     = 1'b0;
    logic [BIN_W-1:0]  value    = '0;
    logic              blank_lz = 1'b0;
    logic [DIGITS-1:0] dp_mask  = '0;
    logic              busy;
    logic              overflow;
    logic [7:0]        led;
    logic [DIGITS-1:0] anode;

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .BIN_W       (BIN_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .busy     (busy),
        .overflow (overflow),
        .led      (led),
        .anode    (anode)
    );

    always #20 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=entry", obs);
        end
        if (sb.size() != 0) begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load v; optionally re-assert load with pv so that it is sampled
    // 'poke' edges after the accepted one. Busy must be high 14 samples.
    task automatic do_load(input logic [BIN_W-1:0] v, input int poke,
                           input logic [BIN_W-1:0] pv);
        for (int i = 0; i < BIN_W; i++) push("busy_high", 32'd1);
        push("busy_low", 32'd0);
        load  = 1'b1;
        value = v;
        for (int i = 0; i < BIN_W + 1; i++) begin
            tick();
            load = (i + 1 == poke);
            if (i + 1 == poke) value = pv;
            pop_chk(32'(busy));
        end
        load = 1'b0;
    endtask

    task automatic check_ovf(input logic e);
        push("overflow", 32'(e));
        pop_chk(32'(overflow));
    endtask

    task automatic check_frame(input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input string tag);
        logic [7:0] exp_led [4];
        logic [3:0] an;
        logic [3:0] prev;
        bit         found;
        exp_led = '{e0, e1, e2, e3};
        for (int d = 0; d < DIGITS; d++) begin
            for (int c = 0; c < REFRESH_DIV; c++) begin
                an = ~(4'b0001 << d);
                push({tag, "_anode"}, 32'(an));
                push({tag, "_led"}, 32'(exp_led[d]));
            end
        end
        found = 1'b0;
        prev  = anode;
        for (int n = 0; n < 40 && !found; n++) begin
            tick();
            if (prev == 4'h7 && anode == 4'hE) found = 1'b1;
            else prev = anode;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL %s_sync observed=timeout expected=anode_7_to_E", tag);
        end
        if (!found) begin
            sb.delete();
        end else begin
            for (int d = 0; d < DIGITS; d++) begin
                for (int c = 0; c < REFRESH_DIV; c++) begin
                    pop_chk(32'(anode));
                    pop_chk(32'(led));
                    tick();
                end
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        push("rst_led", 32'hFF);
        push("rst_anode", 32'hF);
        push("rst_busy", 32'd0);
        push("rst_ovf", 32'd0);
        pop_chk(32'(led));
        pop_chk(32'(anode));
        pop_chk(32'(busy));
        pop_chk(32'(overflow));

        rst_n = 1'b1;
        push("post_rst_anode", 32'hE);
        push("post_rst_led", 32'hC0);
        tick();
        pop_chk(32'(anode));
        pop_chk(32'(led));

        // Basic load, no blanking
        do_load(14'd674, 0, 14'd0);
        check_ovf(1'b0);
        check_frame(8'h99, 8'hF8, 8'h82, 8'hC0, "val674");

        // Leading-zero blanking and decimal point
        blank_lz = 1'b1;
        do_load(14'd7, 0, 14'd0);
        check_frame(8'hF8, 8'hFF, 8'hFF, 8'hFF, "val7_lz");
        do_load(14'd0, 0, 14'd0);
        check_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, "val0_lz");
        dp_mask = 4'b0100;
        check_frame(8'hC0, 8'hFF, 8'h7F, 8'hFF, "val0_dp2");

        // Overflow ignores dp and blanking
        dp_mask = 4'b0001;
        do_load(14'd12000, 0, 14'd0);
        check_ovf(1'b1);
        check_frame(8'hBF, 8'hBF, 8'hBF, 8'hBF, "ovf12000");
        dp_mask = 4'b0000;
        do_load(14'd9999, 0, 14'd0);
        check_ovf(1'b0);
        check_frame(8'h90, 8'h90, 8'h90, 8'h90, "val9999");

        // Load while busy is ignored
        do_load(14'd1234, 2, 14'd5678);
        check_ovf(1'b0);
        check_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, "val1234");

        // Reset in the middle of a conversion
        value = 14'd4321;
        load  = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        push("mid_busy", 32'd1);
        pop_chk(32'(busy));
        rst_n = 1'b0;
        #1;
        push("midrst_led", 32'hFF);
        push("midrst_anode", 32'hF);
        push("midrst_busy", 32'd0);
        push("midrst_ovf", 32'd0);
        pop_chk(32'(led));
        pop_chk(32'(anode));
        pop_chk(32'(busy));
        pop_chk(32'(overflow));
        repeat (2) tick();
        rst_n = 1'b1;
        push("midrel_anode", 32'hE);
        push("midrel_led", 32'hC0);
        tick();
        pop_chk(32'(anode));
        pop_chk(32'(led));
        for (int i = 0; i < 20; i++) push("midrel_idle", 32'd0);
        for (int i = 0; i < 20; i++) begin
            pop_chk(32'(busy));
            tick();
        end
        check_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver and the successor to the fixed three-digit ones/tens/hundred display top. It accepts a binary value through a load handshake and converts it to BCD sequentially (shift-add-3). It then time-multiplexes DIGITS digits onto one shared segment bus, with leading-zero blanking, per-digit decimal points and overflow indication. It sits between the counter/datapath logic and the board's `led`/`anode` pins.

## Interface
- `DIGITS`, default 4: number of digits scanned; minimum 1, maximum 8.
- `BIN_W`, default 14: width of the binary input.
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected; minimum 2.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `load`  in  1: request to capture `value`; accepted only when `busy`=0.
- `value`  in  BIN_W: unsigned binary to display.
- `blank_lz`  in  1: leading-zero blanking enable; sampled live.
- `dp_mask`  in  DIGITS: decimal point enable per digit, bit i is digit i; sampled live.
- `busy`  out  1: conversion in progress.
- `overflow`  out  1: last committed value exceeded 10^DIGITS−1.
- `led`  out  8: segments, active-low; bits [6:0] are g,f,e,d,c,b,a and bit 7 is dp.
- `anode`  out  DIGITS: digit select, active-low, one-hot-zero; bit 0 is the rightmost (ones) digit.

## Operation
- **Load acceptance:** `load`=1 with `busy`=0 captures `value`. It also registers the overflow compare `value > 10^DIGITS−1` (constant compare). `load` while `busy`=1 is ignored; nothing is queued.
- **Conversion FSM:** two states, IDLE and CONV.
  - IDLE→CONV on an accepted load.
  - CONV runs exactly BIN_W shift steps, one per cycle. Before each shift, every 4-bit BCD nibble ≥5 gets +3. The BCD register is 4·DIGITS bits wide, and bits above it are discarded.
  - CONV→IDLE after the final step.
- **Commit:** on the final step, the digit registers and `overflow` update together. The displayed value never shows a partial conversion.
- **Overflow:** when set, every digit shows a dash (`led`=8'hBF). `dp_mask` and `blank_lz` are ignored in this case.
- **Refresh counter:** counts 0..REFRESH_DIV−1. At its terminal count, the digit index advances i→i+1 and wraps from DIGITS−1 to 0. The counter free-runs and is independent of conversion.
- **Leading-zero blanking:** with `blank_lz`=1, digits above the most significant nonzero digit drive 8'hFF. Digit 0 is always shown.
- **Segment codes (dp off):**
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99
  - 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90
- **Decimal point:** `dp_mask[i]`=1 clears bit 7 on digit i. A blanked digit still shows its dp.
- **Reset mid-conversion:** aborts the conversion. The FSM goes to IDLE and the digit registers clear to 0.

## Timing
- **Reset values:**
  - `led`=8'hFF, `anode`=all ones, `busy`=0, `overflow`=0.
  - Digit registers 0, digit index 0, refresh count 0.
- **After reset release:** `led` and `anode` are registered. On the first rising edge after `rst_n` rises, `anode`=~1 (digit 0) and `led` shows digit 0.
- **Load latency:** `load` sampled at edge k.
  - `busy`=1 from edge k+1 through edge k+BIN_W.
  - Digit registers commit at edge k+BIN_W, and `busy`=0 after that edge.
  - `led` reflects the new value from edge k+BIN_W+1 for whichever digit is selected.
- **Back-to-back loads:** earliest next accepted load is at edge k+BIN_W+1.
- **Dwell:** each digit is selected for exactly REFRESH_DIV cycles; the full frame is DIGITS·REFRESH_DIV cycles.
- **Output alignment:** `anode` and `led` change on the same edge. No cycle has two anodes active.
- **Live inputs:** `blank_lz` and `dp_mask` affect `led` one cycle after they change.

## Test plan
Bench configuration: DIGITS=4, BIN_W=14, REFRESH_DIV=4, clk period 40 ns.
1. **Reset:** hold `rst_n`=0 → `led`=FF, `anode`=F, `busy`=0. Release → next edge gives `anode`=E, `led`=C0.
2. **Basic load:** load 674 with `blank_lz`=0 → `busy` high for 14 cycles. Then the scan gives anode E/D/B/7 with `led` 99/F8/82/C0, 4 cycles each, wrapping.
3. **Leading-zero blanking:** `blank_lz`=1.
   - Load 7 → digit 0 = F8, digits 1–3 = FF.
   - Load 0 → digit 0 = C0, rest FF.
   - Set `dp_mask`=4'b0100 → digit 2 = 7F.
4. **Overflow:** load 12000 → `overflow`=1 and all digits BF. Then load 9999 → `overflow`=0 and all digits 90.
5. **Load while busy:** load 1234, then assert `load` with 5678 two cycles later → display 1234; `busy` width is still 14 cycles.
6. **Reset mid-conversion:** load 4321, pull `rst_n` low at cycle 5 → immediate reset values. After release, digit 0 shows C0 and the display never shows 4321.
